// File: rtl/cpu_trace_uart.sv
// Trace word FIFO feeding a UART 8N1 transmitter.
// Each word is sent as raw bytes or as uppercase ASCII hex digits followed by a newline.
module cpu_trace_uart #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 87,
  parameter int HEX_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             overflow,
  output logic                             serial,
  output logic                             busy,
  output logic                             word_done
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH+1);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int NBYTES = DATA_WIDTH/8;
  localparam int NNIB   = DATA_WIDTH/4;
  localparam int NCHARS = (HEX_MODE != 0) ? NNIB+1 : NBYTES;
  localparam int IDX_W  = $clog2(NCHARS+1);

  localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT-1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCHARS-1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]       char_idx_q, char_idx_d;
  logic [7:0]             char_q, char_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;
  logic                   word_done_q, word_done_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  head;
  logic                   push, pop;

  // Character idx of word w, most-significant first; hex words end in a newline.
  function automatic logic [7:0] char_of(input logic [DATA_WIDTH-1:0] w,
                                         input logic [IDX_W-1:0] idx);
    logic [31:0] wx;
    logic [3:0]  nib;
    wx      = 32'(w);
    char_of = 8'h0A;
    if (HEX_MODE == 0) begin
      char_of = 8'(wx >> (8*(NBYTES-1-int'(idx))));
    end else if (int'(idx) < NNIB) begin
      nib     = 4'(wx >> (4*(NNIB-1-int'(idx))));
      char_of = (nib < 4'd10) ? 8'h30 + {4'd0, nib} : 8'h37 + {4'd0, nib};
    end
  endfunction

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // A write into a full FIFO still lands if the FSM pops in the same cycle.
  always_comb begin
    push       = wr_en && (!full_q || pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (wr_en & full_q & ~pop);
    count_d    = CW'(wr_ptr_d - rd_ptr_d);
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    char_idx_d  = char_idx_q;
    char_d      = char_q;
    word_d      = word_q;
    serial_d    = serial_q;
    word_done_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (!empty_q) begin
          pop        = 1'b1;
          word_d     = head;
          char_idx_d = '0;
          char_d     = char_of(head, char_idx_d);
          clk_cnt_d  = '0;
          serial_d   = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = char_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = char_q[bit_idx_d];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (char_idx_q == IDX_LAST) begin
            char_idx_d  = '0;
            word_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Next character's start bit follows the stop bit directly.
            char_idx_d = char_idx_q + IDX_ONE;
            char_d     = char_of(word_q, char_idx_d);
            serial_d   = 1'b0;
            state_d    = START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      char_idx_q  <= '0;
      char_q      <= '0;
      word_q      <= '0;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      char_idx_q  <= char_idx_d;
      char_q      <= char_d;
      word_q      <= word_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign serial    = serial_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_cpu_trace_uart.sv
// Bench for cpu_trace_uart: a raw-mode instance (depth 4) and a hex-mode instance (depth 8),
// both 16-bit words at 4 clocks per bit, checked against a word-level line model.
module tb_cpu_trace_uart;
  localparam int CPB  = 4;
  localparam int MAXC = 20000;
  localparam int FR   = 10*CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b   [2];
  logic        wr_en   [2];
  logic [15:0] wr_data [2];

  logic       full_r, empty_r, overflow_r, serial_r, busy_r, wd_r;
  logic [2:0] count_r;
  logic       full_h, empty_h, overflow_h, serial_h, busy_h, wd_h;
  logic [3:0] count_h;

  cpu_trace_uart #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .HEX_MODE(0)) u_raw (
    .clk(clk), .rst(rst_b[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .full(full_r), .empty(empty_r), .count(count_r), .overflow(overflow_r),
    .serial(serial_r), .busy(busy_r), .word_done(wd_r));

  cpu_trace_uart #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst_b[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .full(full_h), .empty(empty_h), .count(count_h), .overflow(overflow_h),
    .serial(serial_h), .busy(busy_h), .word_done(wd_h));

  // Observation word: {serial, word_done, busy, overflow, full, empty, count[3:0]}
  logic [9:0] obs [2];
  assign obs[0] = {serial_r, wd_r, busy_r, overflow_r, full_r, empty_r, 1'b0, count_r};
  assign obs[1] = {serial_h, wd_h, busy_h, overflow_h, full_h, empty_h, count_h};
  localparam logic [9:0] RST_OBS = 10'b1_0_0_0_0_1_0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] hist [2][MAXC];
  always @(negedge clk) if (cyc < MAXC) begin
    hist[0][cyc] <= obs[0];
    hist[1][cyc] <= obs[1];
  end

  int checks = 0, failures = 0;
  int t0 = 0;
  int wcyc[$];
  logic [15:0] wdat[$];
  int acc_s[$];
  logic [9:0] exp_v [MAXC];

  task automatic push(input int d, input logic [15:0] v);
    @(negedge clk); #1;
    wr_en[d] = 1'b1; wr_data[d] = v;
    wcyc.push_back(cyc + 1); wdat.push_back(v);
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(negedge clk); #1; wr_en[0] = 1'b0; wr_en[1] = 1'b0; end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk); #1;
    rst_b[d] = 1'b0; wr_en[d] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_b[d] = 1'b1;
    t0 = cyc + 1;
    wcyc.delete(); wdat.delete();
  endtask

  function automatic logic [7:0] ref_char(input int d, input logic [15:0] w, input int i);
    int nib;
    if (d == 0) return 8'((w >> (8*(1-i))) & 16'hFF);
    if (i == 4) return 8'h0A;
    nib = int'((w >> (4*(3-i))) & 16'hF);
    return (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
  endfunction

  function automatic logic [7:0] dec(input int d, input int f);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = hist[d][f + CPB + CPB*b + CPB/2][9];
    return v;
  endfunction

  // Word-level model: decide which writes are kept and when each word starts, then paint the line.
  task automatic run_model(input int d, input int t1);
    int depth, len, ovf_at, s, cnt, ln;
    logic pop_now, sr, wdn, bz;
    logic [7:0] ch;
    int acc_w[$];
    logic [15:0] acc_d[$];
    depth = d ? 8 : 4;
    len = (d ? 5 : 2) * FR;
    ovf_at = -1;
    acc_s.delete();
    foreach (wcyc[i]) begin
      cnt = 0; pop_now = 1'b0;
      foreach (acc_s[k]) begin
        if (acc_w[k] <= wcyc[i]-1 && acc_s[k] > wcyc[i]-1) cnt++;
        if (acc_s[k] == wcyc[i]) pop_now = 1'b1;
      end
      if (cnt == depth && !pop_now) begin
        if (ovf_at < 0) ovf_at = wcyc[i];
      end else begin
        s = wcyc[i] + 1;
        if (acc_s.size() > 0 && acc_s[$] + len + 1 > s) s = acc_s[$] + len + 1;
        acc_s.push_back(s); acc_w.push_back(wcyc[i]); acc_d.push_back(wdat[i]);
      end
    end
    for (int c = t0; c <= t1; c++) begin
      sr = 1'b1; wdn = 1'b0; bz = 1'b0; cnt = 0;
      foreach (acc_s[k]) begin
        if (c >= acc_s[k] && c < acc_s[k] + len) begin
          bz = 1'b1;
          ln = (c - acc_s[k]) % FR;
          ch = ref_char(d, acc_d[k], (c - acc_s[k]) / FR);
          sr = (ln < CPB) ? 1'b0 : (ln < 9*CPB) ? ch[(ln-CPB)/CPB] : 1'b1;
        end
        if (c == acc_s[k] + len) wdn = 1'b1;
        if (acc_w[k] <= c && acc_s[k] > c) cnt++;
      end
      exp_v[c] = {sr, wdn, bz, (ovf_at >= 0 && c >= ovf_at), (cnt == depth), (cnt == 0), 4'(cnt)};
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== RST_OBS) begin
        failures++; $display("FAIL reset_state dut%0d got %b want %b", d, obs[d], RST_OBS);
      end
    end
    rst_b[0] = 1'b1; rst_b[1] = 1'b1;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== RST_OBS) begin
        failures++; $display("FAIL reset_release dut%0d got %b want %b", d, obs[d], RST_OBS);
      end
    end
  endtask

  task automatic test_raw_single();
    int w, s, n, nbad, first;
    do_reset(0);
    push(0, 16'hA55A);
    gap(90);
    w = wcyc[0]; s = w + 1;
    checks++;
    if ({hist[0][w][9], hist[0][s][9]} !== 2'b10) begin
      failures++; $display("FAIL raw_serial_fall got %b want 10", {hist[0][w][9], hist[0][s][9]});
    end
    checks++;
    if ({hist[0][w][3:0], hist[0][s][3:0]} !== 8'h10) begin
      failures++; $display("FAIL raw_count_latency got %h want 10", {hist[0][w][3:0], hist[0][s][3:0]});
    end
    checks++;
    if ({dec(0, s), dec(0, s+FR)} !== 16'hA55A) begin
      failures++; $display("FAIL raw_decode got %h want a55a", {dec(0, s), dec(0, s+FR)});
    end
    n = 0;
    for (int c = t0; c <= cyc; c++) if (hist[0][c][8]) n++;
    checks++;
    if (n != 1 || {hist[0][s+79][8:7], hist[0][s+80][8:7]} !== 4'b0110) begin
      failures++; $display("FAIL raw_word_done pulses=%0d got %b want 1 pulse and 0110", n,
                           {hist[0][s+79][8:7], hist[0][s+80][8:7]});
    end
    run_model(0, cyc);
    nbad = 0; first = -1;
    for (int c = t0; c <= cyc; c++) if (hist[0][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
    checks++;
    if (nbad != 0) begin
      failures++; $display("FAIL raw_single_model bad=%0d cyc=%0d got %b want %b", nbad, first, hist[0][first], exp_v[first]);
    end
  endtask

  task automatic test_hex_single();
    int s, nbad, first;
    logic [39:0] got;
    do_reset(1);
    push(1, 16'h1F3C);
    gap(210);
    s = wcyc[0] + 1;
    got = '0;
    for (int k = 0; k < 5; k++) got = {got[31:0], dec(1, s + FR*k)};
    checks++;
    if (got !== 40'h314633430A) begin
      failures++; $display("FAIL hex_decode got %h want 314633430a", got);
    end
    checks++;
    if ({hist[1][s+199][9:8], hist[1][s+200][8:7], hist[1][s+FR][9]} !== 5'b10100) begin
      failures++; $display("FAIL hex_timing got %b want 10100",
                           {hist[1][s+199][9:8], hist[1][s+200][8:7], hist[1][s+FR][9]});
    end
    run_model(1, cyc);
    nbad = 0; first = -1;
    for (int c = t0; c <= cyc; c++) if (hist[1][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
    checks++;
    if (nbad != 0) begin
      failures++; $display("FAIL hex_single_model bad=%0d cyc=%0d got %b want %b", nbad, first, hist[1][first], exp_v[first]);
    end
  endtask

  task automatic test_overflow();
    int w6, s1, nbad, first;
    logic [79:0] got;
    do_reset(0);
    for (int v = 1; v <= 6; v++) push(0, 16'(v));
    gap(5*81 + 10);
    w6 = wcyc[5]; s1 = wcyc[0] + 1;
    checks++;
    if ({hist[0][w6-1][6:0], hist[0][w6][6:0]} !== 14'b0100100_1100100) begin
      failures++; $display("FAIL ovf_full got %b want 01001001100100", {hist[0][w6-1][6:0], hist[0][w6][6:0]});
    end
    checks++;
    if (hist[0][cyc][6] !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got %b want 1", hist[0][cyc][6]);
    end
    got = '0;
    for (int k = 0; k < 5; k++) got = {got[63:0], dec(0, s1 + 81*k), dec(0, s1 + 81*k + FR)};
    checks++;
    if (got !== 80'h0001_0002_0003_0004_0005) begin
      failures++; $display("FAIL ovf_order got %h want 00010002000300040005", got);
    end
    run_model(0, cyc);
    nbad = 0; first = -1;
    for (int c = t0; c <= cyc; c++) if (hist[0][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
    checks++;
    if (nbad != 0) begin
      failures++; $display("FAIL ovf_model bad=%0d cyc=%0d got %b want %b", nbad, first, hist[0][first], exp_v[first]);
    end
  endtask

  task automatic test_full_pop_write();
    int s1, wx, nbad, first;
    do_reset(0);
    for (int v = 1; v <= 5; v++) push(0, 16'(v));
    s1 = wcyc[0] + 1;
    gap(s1 + 81 - wcyc[4] - 1);
    push(0, 16'h00AA);
    gap(5*81 + 10);
    wx = wcyc[5];
    checks++;
    if ({hist[0][wx-1][8], hist[0][wx-1][5], hist[0][wx-1][3:0]} !== 6'b1_1_0100) begin
      failures++; $display("FAIL fullpop_before got %b want 110100", {hist[0][wx-1][8], hist[0][wx-1][5], hist[0][wx-1][3:0]});
    end
    checks++;
    if ({hist[0][wx][6:0], hist[0][cyc][6]} !== 8'b0100100_0) begin
      failures++; $display("FAIL fullpop_after got %b want 01001000", {hist[0][wx][6:0], hist[0][cyc][6]});
    end
    checks++;
    if (dec(0, s1 + 5*81 + FR) !== 8'hAA) begin
      failures++; $display("FAIL fullpop_word got %h want aa", dec(0, s1 + 5*81 + FR));
    end
    run_model(0, cyc);
    nbad = 0; first = -1;
    for (int c = t0; c <= cyc; c++) if (hist[0][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
    checks++;
    if (nbad != 0) begin
      failures++; $display("FAIL fullpop_model bad=%0d cyc=%0d got %b want %b", nbad, first, hist[0][first], exp_v[first]);
    end
  endtask

  task automatic test_reset_mid();
    int s1, nbad, first;
    do_reset(0);
    for (int v = 1; v <= 6; v++) push(0, 16'(v));
    s1 = wcyc[0] + 1;
    gap(s1 + 50 - cyc);
    checks++;
    if ({hist[0][cyc][7], hist[0][cyc][6]} !== 2'b11) begin
      failures++; $display("FAIL rstmid_pre busy/ovf got %b want 11", {hist[0][cyc][7], hist[0][cyc][6]});
    end
    rst_b[0] = 1'b0;
    #1;
    checks++;
    if (obs[0] !== RST_OBS) begin
      failures++; $display("FAIL rstmid_async got %b want %b", obs[0], RST_OBS);
    end
    repeat (2) @(negedge clk);
    #1 rst_b[0] = 1'b1;
    t0 = cyc + 1;
    wcyc.delete(); wdat.delete();
    push(0, 16'h3C5A);
    gap(90);
    checks++;
    if ({dec(0, wcyc[0]+1), dec(0, wcyc[0]+1+FR)} !== 16'h3C5A) begin
      failures++; $display("FAIL rstmid_new_word got %h want 3c5a", {dec(0, wcyc[0]+1), dec(0, wcyc[0]+1+FR)});
    end
    run_model(0, cyc);
    nbad = 0; first = -1;
    for (int c = t0; c <= cyc; c++) if (hist[0][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
    checks++;
    if (nbad != 0) begin
      failures++; $display("FAIL rstmid_model bad=%0d cyc=%0d got %b want %b", nbad, first, hist[0][first], exp_v[first]);
    end
  endtask

  task automatic test_back_to_back();
    int s1, nbad, first;
    do_reset(0);
    push(0, 16'hFFFF);
    push(0, 16'h0000);
    gap(175);
    s1 = wcyc[0] + 1;
    checks++;
    if ({hist[0][s1+79][9], hist[0][s1+80][9:8], hist[0][s1+81][9]} !== 4'b1110) begin
      failures++; $display("FAIL b2b_gap got %b want 1110", {hist[0][s1+79][9], hist[0][s1+80][9:8], hist[0][s1+81][9]});
    end
    checks++;
    if ({dec(0, s1), dec(0, s1+FR), dec(0, s1+81), dec(0, s1+81+FR)} !== 32'hFFFF_0000) begin
      failures++; $display("FAIL b2b_decode got %h want ffff0000",
                           {dec(0, s1), dec(0, s1+FR), dec(0, s1+81), dec(0, s1+81+FR)});
    end
    run_model(0, cyc);
    nbad = 0; first = -1;
    for (int c = t0; c <= cyc; c++) if (hist[0][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
    checks++;
    if (nbad != 0) begin
      failures++; $display("FAIL b2b_model bad=%0d cyc=%0d got %b want %b", nbad, first, hist[0][first], exp_v[first]);
    end
  endtask

  task automatic test_random();
    int g, nbad, first;
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int i = 0; i < (d ? 12 : 25); i++) begin
        push(d, 16'($urandom));
        g = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, d ? 260 : 110));
        if (g > 0) gap(g);
      end
      gap(d ? 1900 : 500);
      run_model(d, cyc);
      nbad = 0; first = -1;
      for (int c = t0; c <= cyc; c++) if (hist[d][c] !== exp_v[c]) begin nbad++; if (first < 0) first = c; end
      checks++;
      if (nbad != 0) begin
        failures++; $display("FAIL random_model dut%0d bad=%0d cyc=%0d got %b want %b", d, nbad, first, hist[d][first], exp_v[first]);
      end
    end
  endtask

  initial begin
    rst_b[0] = 1'b0; rst_b[1] = 1'b0;
    wr_en[0] = 1'b0; wr_en[1] = 1'b0;
    wr_data[0] = '0; wr_data[1] = '0;
    test_reset();
    test_raw_single();
    test_hex_single();
    test_overflow();
    test_full_pop_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_uart.md
# cpu_trace_uart

Parametrised trace-output unit for the CPU test datapath. It accepts full-width register writeback words from the CPU through a single-cycle write strobe and buffers them in a FIFO. Each word is serialised as UART 8N1 characters, either as raw bytes or as ASCII hex followed by a newline. It replaces the single-byte encoder-plus-transmitter path. The CPU can issue back-to-back writes without waiting on the line, and the full word is sent rather than one byte of it.

## Interface
Parameters:
- DATA_WIDTH, 16: trace word width. Must be a multiple of 8 and at most 32.
- FIFO_DEPTH, 8: FIFO entries. Power of two, at least 2.
- CLKS_PER_BIT, 87: clock cycles per UART bit. At least 2.
- HEX_MODE, 0: 0 sends raw bytes; 1 sends ASCII hex characters plus 0x0A.

Ports:
- clk  in  1: single clock. All state changes on its rising edge.
- rst  in  1: asynchronous, active-low reset.
- wr_en  in  1: push wr_data this cycle.
- wr_data  in  DATA_WIDTH: trace word.
- full  out  1: FIFO holds FIFO_DEPTH words.
- empty  out  1: FIFO holds 0 words.
- count  out  $clog2(FIFO_DEPTH+1): number of words currently in the FIFO.
- overflow  out  1: sticky. Set when a write is dropped.
- serial  out  1: UART TX line. Idles high.
- busy  out  1: FSM is not in IDLE.
- word_done  out  1: one-cycle pulse after the last stop bit of a word.

## Operation
- Reset (rst=0) takes effect immediately and clears the following:
  - FIFO pointers; count=0, empty=1, full=0.
  - overflow=0.
  - serial=1, busy=0, word_done=0.
  - FSM forced to IDLE and all counters zeroed.
  - Any frame in flight is abandoned, with no partial stop bit.
- FIFO write rules:
  - wr_en while not full stores the word.
  - wr_en while full is accepted only if a pop happens in the same cycle. Otherwise the word is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
- FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is not empty, pop the head into the word register, set char index 0, load the first character, go to START. Otherwise stay in IDLE.
  - START: serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: serial=1 for CLKS_PER_BIT cycles. Then:
    - if more characters remain in the word, load the next one and go to START, with no idle gap;
    - otherwise go to IDLE and pulse word_done in that first IDLE cycle.
- Raw mode character sequence:
  - DATA_WIDTH/8 bytes, most-significant byte first.
- Hex mode character sequence:
  - DATA_WIDTH/4 nibbles, most-significant first.
  - Nibble 0–9 maps to 0x30+n; nibble A–F maps to 0x41+(n-10), uppercase.
  - Then one 0x0A character.
  - Character count per word is DATA_WIDTH/4+1.
- The character index counter wraps at the character count. The FIFO pointers wrap modulo FIFO_DEPTH, and one extra bit distinguishes full from empty.

## Timing
- All outputs are registered.
- Write-to-line latency, when idle and the FIFO is empty:
  - wr_en is sampled at edge E;
  - the word is popped and serial falls at edge E+1;
  - count reads 1 between E and E+1, then 0.
- Character frame length: 10·CLKS_PER_BIT cycles.
- Word length:
  - raw mode: (DATA_WIDTH/8)·10·CLKS_PER_BIT cycles;
  - hex mode: (DATA_WIDTH/4+1)·10·CLKS_PER_BIT cycles.
- Gap between words: exactly 1 clock cycle (the IDLE cycle carrying word_done). The next start bit begins at the following edge.
- busy:
  - high from the pop edge through the last stop-bit cycle;
  - low in the word_done cycle.
- Reset release: serial is high on the first edge after reset deasserts. A pending write is not possible, because the FIFO is empty.

## Test plan
Directed tests use CLKS_PER_BIT=4 and DATA_WIDTH=16.
- Raw mode, one write of 0xA55A while idle:
  - serial falls 1 cycle after the write;
  - two frames decode to 0xA5 then 0x5A, 80 cycles total;
  - word_done pulses once, 1 cycle after the final stop bit;
  - busy drops in that same cycle.
- HEX_MODE=1, write 0x1F3C:
  - frames decode to 0x31, 0x46, 0x33, 0x43, 0x0A, 200 cycles total, with no gaps between characters.
- FIFO_DEPTH=4, raw mode, six consecutive writes of 0x0001 through 0x0006 starting from idle:
  - word 1 is popped immediately; words 2–5 fill the FIFO;
  - full=1, count=4;
  - word 6 is dropped and overflow=1 stays set;
  - line output is words 1–5 in order, separated by 1-cycle gaps.
- Full FIFO with a write landing in the word_done/pop cycle:
  - the write is accepted, count stays 4, overflow stays 0.
- rst pulsed low during DATA of the second byte:
  - serial=1 immediately and count=0;
  - busy, word_done and overflow are all 0;
  - a write after release transmits a complete new word.
- Back-to-back writes of 0xFFFF and 0x0000 in raw mode:
  - the stop bit of the last 0xFF byte is followed by exactly one idle-high cycle, then the start bit of 0x00.
